// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default multiply/divide occupancy and the register-index width.
package pipe_pkg;

  localparam int MDU_LAT_DEFAULT = 32;
  localparam int REG_IDX_W       = 5;
  localparam int STALL_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MDU_DONE = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
//
// Handshake semantics: there is no valid/ready pair on this bundle. Every
// input is a level that describes the current ID/EX contents for this cycle
// and every output is a level that applies to the coming clock edge.
// stall_cycles_wr is a single-cycle write strobe that loads stall_cycles_wdata
// into the stall performance counter at the next edge (reset takes priority).
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  // ID/EX observation inputs
  logic [REG_IDX_W-1:0]   id_rs;
  logic [REG_IDX_W-1:0]   id_rt;
  logic                   id_uses_rt;
  logic                   ex_mem_read;
  logic [REG_IDX_W-1:0]   ex_rt;
  logic                   ex_mdu;
  logic                   ex_branch_taken;

  // Performance counter write port
  logic                   stall_cycles_wr;
  logic [STALL_CNT_W-1:0] stall_cycles_wdata;

  // Pipeline control outputs
  logic                   pc_en;
  logic                   ifid_en;
  logic                   idex_en;
  logic                   exmem_en;
  logic                   memwb_en;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   mdu_busy;
  logic                   mdu_done;
  logic [STALL_CNT_W-1:0] stall_cycles;

  // Debug visibility of the controller FSM
  hz_state_e              dbg_state;
  logic [7:0]             dbg_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_mdu, ex_branch_taken,
    output stall_cycles_wr, stall_cycles_wdata,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, mdu_busy, mdu_done, stall_cycles,
    input  dbg_state, dbg_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_mdu, ex_branch_taken,
    input  stall_cycles_wr, stall_cycles_wdata,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, mdu_busy, mdu_done, stall_cycles,
    output dbg_state, dbg_cnt
  );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit saturating up-counter with synchronous reset and a load port.
// Priority: rst > load > inc. Once at all-ones it holds there until reset
// or load.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] count
);

  // Count up on inc, stopping at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline.
// Handles, in priority order: multi-cycle mult/div occupancy (freezes the
// front end and EX for MDU_LAT cycles, then a one-cycle commit pulse),
// taken branches (flush IF/ID and ID/EX), and load-use hazards (one bubble).
// MDU_LAT legal range is 2..255.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_e  state;
  logic [7:0] cnt;
  logic       load_use;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, mdu_busy, mdu_done;

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. $0 is hardwired zero, so it never creates a dependency.
  assign load_use = hz.ex_mem_read && (hz.ex_rt != '0) &&
                    ((hz.ex_rt == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // Combinational pipeline control from current state and ID/EX contents.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mdu_busy   = 1'b0;
    mdu_done   = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_RUN: begin
          if (hz.ex_mdu) begin
            // Freeze everything up to EX; let the older instruction in MEM
            // drain to WB.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            mdu_busy = 1'b1;
          end else if (hz.ex_branch_taken) begin
            // Younger instructions are on the wrong path; a coincident
            // load-use is irrelevant because its consumer is killed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            // Hold IF and ID, insert one bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          mdu_busy = 1'b1;
        end
        ST_MDU_DONE: begin
          // The mult/div leaves EX this cycle; its ex_mdu flag is ignored so
          // it does not restart the occupancy window.
          mdu_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM and occupancy counter: the RUN entry cycle plus MDU_LAT-1 wait
  // cycles give exactly MDU_LAT held cycles before the commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (hz.ex_mdu) begin
            state <= ST_MDU_WAIT;
            cnt   <= 8'(MDU_LAT - 1);
          end
        end
        ST_MDU_WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= ST_MDU_DONE;
          end
        end
        ST_MDU_DONE: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  sat_counter32 u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (~pc_en),
    .load     (hz.stall_cycles_wr),
    .load_val (hz.stall_cycles_wdata),
    .count    (hz.stall_cycles)
  );

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.idex_en    = idex_en;
  assign hz.exmem_en   = exmem_en;
  assign hz.memwb_en   = memwb_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.mdu_busy   = mdu_busy;
  assign hz.mdu_done   = mdu_done;
  assign hz.dbg_state  = state;
  assign hz.dbg_cnt    = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int LAT = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cycles of MDU hold still to come, commit pending flag,
  // expected stall counter.
  int          m_hold;
  bit          m_done_pend;
  logic [31:0] m_stall;

  // Output vector order: pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, busy, done
  localparam logic [8:0] O_DEF  = 9'b111110000;
  localparam logic [8:0] O_MDU  = 9'b000010010;
  localparam logic [8:0] O_DONE = 9'b111110001;
  localparam logic [8:0] O_BR   = 9'b111111100;
  localparam logic [8:0] O_LU   = 9'b001110100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_out();
    bit lu;
    lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
         ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    if (rst)                     return O_DEF;
    if (m_hold > 0)              return O_MDU;
    if (m_done_pend)             return O_DONE;
    if (hz.ex_mdu)               return O_MDU;
    if (hz.ex_branch_taken)      return O_BR;
    if (lu)                      return O_LU;
    return O_DEF;
  endfunction

  function automatic logic [8:0] dut_out();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.mdu_busy, hz.mdu_done};
  endfunction

  // Driver: inputs already set by caller at the negedge; check, clock, update model.
  task automatic cycle(input string tag);
    logic [8:0] e;
    #1;
    e = exp_out();
    chk({tag, "_outs"}, {23'd0, dut_out()}, {23'd0, e});
    chk({tag, "_stall"}, hz.stall_cycles, m_stall);
    @(posedge clk);
    if (rst) begin
      m_hold = 0;
      m_done_pend = 1'b0;
      m_stall = '0;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_done_pend = 1'b1;
      end else if (m_done_pend) begin
        m_done_pend = 1'b0;
      end else if (hz.ex_mdu) begin
        m_hold = LAT - 1;
      end
      if (hz.stall_cycles_wr) m_stall = hz.stall_cycles_wdata;
      else if (!e[8] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    hz.id_rs = '0;
    hz.id_rt = '0;
    hz.id_uses_rt = 1'b0;
    hz.ex_mem_read = 1'b0;
    hz.ex_rt = '0;
    hz.ex_mdu = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.stall_cycles_wr = 1'b0;
    hz.stall_cycles_wdata = '0;
  endtask

  initial begin
    int busy_n;
    int done_at;
    m_hold = 0;
    m_done_pend = 1'b0;
    m_stall = '0;
    idle();
    rst = 1'b1;
    @(negedge clk);

    // Reset with hazard inputs present: outputs must stay default.
    hz.ex_mdu = 1'b1;
    hz.ex_mem_read = 1'b1;
    hz.ex_rt = 5'd5;
    hz.id_rs = 5'd5;
    cycle("rst_a");
    cycle("rst_b");
    rst = 1'b0;
    idle();
    cycle("idle");
    chk("reset_state", 32'(hz.dbg_state), 32'(ST_RUN));

    // Load-use on rs: one bubble, counter 0 -> 1.
    hz.ex_mem_read = 1'b1;
    hz.ex_rt = 5'd5;
    hz.id_rs = 5'd5;
    cycle("load_use");
    chk("lu_stall_cnt", hz.stall_cycles, 32'd1);
    idle();
    cycle("after_lu");

    // $0 never stalls.
    hz.ex_mem_read = 1'b1;
    hz.ex_rt = 5'd0;
    hz.id_rs = 5'd0;
    hz.id_rt = 5'd0;
    hz.id_uses_rt = 1'b1;
    cycle("reg0");
    chk("reg0_stall_cnt", hz.stall_cycles, 32'd1);

    // Branch with concurrent load-use on rt: flush, no stall.
    idle();
    hz.ex_branch_taken = 1'b1;
    hz.ex_mem_read = 1'b1;
    hz.ex_rt = 5'd7;
    hz.id_rt = 5'd7;
    hz.id_uses_rt = 1'b1;
    cycle("br_lu");
    chk("br_lu_stall_cnt", hz.stall_cycles, 32'd1);

    // MDU with branch also present: MDU wins for LAT cycles, then commit.
    idle();
    hz.ex_mdu = 1'b1;
    hz.ex_branch_taken = 1'b1;
    busy_n = 0;
    done_at = 0;
    for (int i = 1; i <= LAT + 1; i++) begin
      #1;
      if (hz.mdu_busy) busy_n++;
      if (hz.mdu_done) done_at = i;
      cycle("mdu");
    end
    chk("mdu_busy_cycles", 32'(busy_n), 32'(LAT));
    chk("mdu_done_cycle", 32'(done_at), 32'(LAT + 1));
    chk("mdu_stall_cnt", hz.stall_cycles, 32'(1 + LAT));
    chk("mdu_back_run", 32'(hz.dbg_state), 32'(ST_RUN));
    hz.ex_mdu = 1'b0;
    cycle("br_after_mdu");

    // Reset on the 10th MDU_WAIT cycle.
    idle();
    hz.ex_mdu = 1'b1;
    cycle("mdu_enter");
    hz.ex_mdu = 1'b0;
    for (int i = 1; i <= 9; i++) cycle("mdu_wait");
    rst = 1'b1;
    cycle("rst_mid");
    rst = 1'b0;
    chk("rst_mid_stall", hz.stall_cycles, 32'd0);
    chk("rst_mid_busy", 32'(hz.mdu_busy), 32'd0);
    chk("rst_mid_state", 32'(hz.dbg_state), 32'(ST_RUN));
    cycle("after_rst");

    // Saturation from 0xFFFFFFFE.
    hz.stall_cycles_wr = 1'b1;
    hz.stall_cycles_wdata = 32'hFFFF_FFFE;
    cycle("preload");
    idle();
    chk("preload_val", hz.stall_cycles, 32'hFFFF_FFFE);
    hz.ex_mem_read = 1'b1;
    hz.ex_rt = 5'd3;
    hz.id_rs = 5'd3;
    cycle("sat1");
    cycle("sat2");
    chk("sat_max", hz.stall_cycles, 32'hFFFF_FFFF);
    cycle("sat3");
    chk("sat_hold", hz.stall_cycles, 32'hFFFF_FFFF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      hz.id_rs = 5'($urandom_range(0, 7));
      hz.id_rt = 5'($urandom_range(0, 7));
      hz.ex_rt = 5'($urandom_range(0, 7));
      hz.id_uses_rt = 1'($urandom_range(0, 1));
      hz.ex_mem_read = 1'($urandom_range(0, 1));
      hz.ex_mdu = ($urandom_range(0, 19) == 0);
      hz.ex_branch_taken = ($urandom_range(0, 3) == 0);
      hz.stall_cycles_wr = ($urandom_range(0, 49) == 0);
      hz.stall_cycles_wdata = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFD : $urandom;
      rst = ($urandom_range(0, 79) == 0);
      cycle("rand");
    end
    rst = 1'b0;
    idle();
    cycle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
